// File: rtl/handshake_req_issuer.sv
// handshake_req_issuer
// Strobe-side front end of a four-phase stb/ack crossing handshake.
// Words arrive on a valid/ready stream, wait in a small FIFO, and each
// word is issued as one four-phase transaction:
//   raise stb -> wait ack high -> drop stb -> wait ack low.
// A REQ phase that waits too long for ack is aborted. The word is
// discarded and a sticky timeout_err flag is raised.
//
// Handshake rule for the input stream: a word transfers on every rising
// clk edge where in_valid and in_ready are both high. in_ready depends
// only on registered FIFO state and never on in_valid, so the upstream
// may hold in_valid/in_data until it sees the transfer.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = REQ, 2 = RELEASE.

module handshake_req_issuer #(
    parameter int DATA_W         = 32,
    parameter int DEPTH_LOG2     = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              stb,
    input  logic              ack,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // Last counter value allowed in REQ; the abort fires on this cycle.
    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // ack synchronizer
    // ------------------------------------------------------------------
    logic w_ack_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_ack_s = ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // Shift ack through SYNC_STAGES flops; the last flop is ack_s.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= ack;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_ack_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   w_head;

    // The extra top pointer bit tells a full FIFO from an empty one when
    // the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_push  = in_valid & ~w_full;
    assign w_head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    // Storage array; no reset needed because data is only read when the
    // FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
        end
    end

    // Read/write pointers; push and pop may happen on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_stb;
    logic              r_done;
    logic              r_err;
    logic              r_aborted;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic              w_timeout_hit;
    logic              w_abort;

    assign w_timeout_hit = TO_EN && (r_to_cnt == TO_LAST);
    // The word leaves the FIFO when REQ ends, whether acked or aborted.
    assign w_pop   = (r_state == ST_REQ) && (w_ack_s || w_timeout_hit);
    assign w_abort = (r_state == ST_REQ) && !w_ack_s && w_timeout_hit;

    // Four-phase sequencing, timeout abort, done pulse and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_stb      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_aborted  <= 1'b0;
            r_to_cnt   <= '0;
            r_out_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A stale ack (e.g. late ack of an aborted word) must
                    // be gone before a new request starts.
                    if (!w_empty && !w_ack_s) begin
                        r_state    <= ST_REQ;
                        r_stb      <= 1'b1;
                        r_to_cnt   <= '0;
                        r_out_data <= w_head;
                    end
                end
                ST_REQ: begin
                    if (w_ack_s) begin
                        r_state <= ST_RELEASE;
                        r_stb   <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_state   <= ST_RELEASE;
                        r_stb     <= 1'b0;
                        r_aborted <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!w_ack_s) begin
                        r_state   <= ST_IDLE;
                        r_done    <= ~r_aborted;
                        r_aborted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stb   <= 1'b0;
                end
            endcase

            // A new abort outranks a clear arriving on the same cycle.
            if (w_abort) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = ~w_full;
    assign stb         = r_stb;
    assign out_data    = r_out_data;
    assign busy        = (r_state != ST_IDLE) | ~w_empty;
    assign done        = r_done;
    assign timeout_err = r_err;
    assign dbg_state   = r_state;

endmodule
